// File: rtl/seg_frame_serializer.sv
// Serialises packed BCD digits and decimal points into the external 7-segment shift-register chain.
// Optional macro DISP_HEX_EN: when defined, codes 10..15 show A,b,C,d,E,F instead of blanking.
module seg_frame_serializer #(
    parameter int NUM_DIGITS      = 6,
    parameter int BIT_HALF_CYCLES = 50,
    parameter int DWELL_CYCLES    = 10_000,
    parameter int NRST_CYCLES     = 100
) (
    input  logic                    g_clk,
    input  logic                    g_nrst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   decimals_in,
    output logic                    frame_done,
    output logic                    all_nrst,
    output logic                    control_reg_clk,
    output logic                    all_bit_clk,
    output logic                    control_data_ser,
    output logic                    digit_data_ser
);

    localparam int MAX_A   = (BIT_HALF_CYCLES > DWELL_CYCLES) ? BIT_HALF_CYCLES : DWELL_CYCLES;
    localparam int MAX_CYC = (MAX_A > NRST_CYCLES) ? MAX_A : NRST_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(BIT_HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] NRST_LAST  = CNT_W'(NRST_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        RST_HOLD,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH_HI,
        LATCH_LO,
        DWELL
    } state_t;

    // Segment order is {g, f, e, d, c, b, a}; 1 lights the segment.
    function automatic logic [6:0] seg_code(input logic [3:0] value);
        logic [6:0] code;
        case (value)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
`ifdef DISP_HEX_EN
            4'd10:   code = 7'h77;
            4'd11:   code = 7'h7C;
            4'd12:   code = 7'h39;
            4'd13:   code = 7'h5E;
            4'd14:   code = 7'h79;
            4'd15:   code = 7'h71;
`endif
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [2:0]              bit_cnt, bit_cnt_nxt;
    logic [IDX_W-1:0]        digit_idx, digit_idx_nxt;
    logic [4*NUM_DIGITS-1:0] shadow_digits, shadow_digits_nxt;
    logic [NUM_DIGITS-1:0]   shadow_dps, shadow_dps_nxt;
    logic [7:0]              seg_byte, seg_byte_nxt;
    logic [7:0]              sel_byte, sel_byte_nxt;
    logic [3:0]              cur_digit;
    logic                    cur_dp;

    logic frame_done_nxt;
    logic all_nrst_nxt;
    logic control_reg_clk_nxt;
    logic all_bit_clk_nxt;
    logic control_data_ser_nxt;
    logic digit_data_ser_nxt;

    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt;
        bit_cnt_nxt       = bit_cnt;
        digit_idx_nxt     = digit_idx;
        shadow_digits_nxt = shadow_digits;
        shadow_dps_nxt    = shadow_dps;
        seg_byte_nxt      = seg_byte;
        sel_byte_nxt      = sel_byte;
        cur_digit         = 4'd0;
        cur_dp            = 1'b0;

        case (state)
            RST_HOLD: begin
                if (cnt == NRST_LAST) begin
                    state_nxt     = LOAD;
                    cnt_nxt       = '0;
                    digit_idx_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LOAD: begin
                // The frame snapshot is taken once, so every digit of a frame comes from the same sample.
                if (digit_idx == '0) begin
                    shadow_digits_nxt = digits_in;
                    shadow_dps_nxt    = decimals_in;
                end
                cur_digit    = shadow_digits_nxt[4*digit_idx +: 4];
                cur_dp       = shadow_dps_nxt[digit_idx];
                seg_byte_nxt = {cur_dp, seg_code(cur_digit)};
                sel_byte_nxt = 8'd1 << digit_idx;
                bit_cnt_nxt  = '0;
                cnt_nxt      = '0;
                state_nxt    = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (cnt == HALF_LAST) begin
                    state_nxt = SHIFT_HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = LATCH_HI;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        state_nxt   = SHIFT_LO;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LATCH_HI: begin
                if (cnt == HALF_LAST) begin
                    state_nxt = LATCH_LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LATCH_LO: begin
                if (cnt == HALF_LAST) begin
                    state_nxt = DWELL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DWELL: begin
                if (cnt == DWELL_LAST) begin
                    state_nxt     = LOAD;
                    cnt_nxt       = '0;
                    digit_idx_nxt = (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RST_HOLD;
                cnt_nxt   = '0;
            end
        endcase

        // Pin values are decoded from the upcoming state so every output leaves a flop.
        all_nrst_nxt         = (state_nxt != RST_HOLD);
        all_bit_clk_nxt      = (state_nxt == SHIFT_HI);
        control_reg_clk_nxt  = (state_nxt == LATCH_HI);
        frame_done_nxt       = (state_nxt == DWELL) && (cnt_nxt == DWELL_LAST) &&
                               (digit_idx == LAST_IDX);
        control_data_ser_nxt = control_data_ser;
        digit_data_ser_nxt   = digit_data_ser;
        if ((state_nxt == SHIFT_LO) && (state != SHIFT_LO)) begin
            digit_data_ser_nxt   = seg_byte_nxt[~bit_cnt_nxt];
            control_data_ser_nxt = sel_byte_nxt[~bit_cnt_nxt];
        end else if ((state_nxt != SHIFT_LO) && (state_nxt != SHIFT_HI)) begin
            digit_data_ser_nxt   = 1'b0;
            control_data_ser_nxt = 1'b0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_nrst) begin
            state            <= RST_HOLD;
            cnt              <= '0;
            bit_cnt          <= '0;
            digit_idx        <= '0;
            shadow_digits    <= '0;
            shadow_dps       <= '0;
            seg_byte         <= '0;
            sel_byte         <= '0;
            frame_done       <= 1'b0;
            all_nrst         <= 1'b0;
            control_reg_clk  <= 1'b0;
            all_bit_clk      <= 1'b0;
            control_data_ser <= 1'b0;
            digit_data_ser   <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            bit_cnt          <= bit_cnt_nxt;
            digit_idx        <= digit_idx_nxt;
            shadow_digits    <= shadow_digits_nxt;
            shadow_dps       <= shadow_dps_nxt;
            seg_byte         <= seg_byte_nxt;
            sel_byte         <= sel_byte_nxt;
            frame_done       <= frame_done_nxt;
            all_nrst         <= all_nrst_nxt;
            control_reg_clk  <= control_reg_clk_nxt;
            all_bit_clk      <= all_bit_clk_nxt;
            control_data_ser <= control_data_ser_nxt;
            digit_data_ser   <= digit_data_ser_nxt;
        end
    end

endmodule
